// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared types and constants for the FT232H 245 synchronous FIFO engines
package ftdi_pkg;

  localparam int FTDI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    READ
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_TURN,
    TX_WRITE
  } tx_state_t;

endpackage

// File: rtl/ft232h_rx_fifo.sv
// rtl/ft232h_rx_fifo.sv - single-clock byte FIFO with registered count and registered head output
module ft232h_rx_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [FTDI_DATA_W-1:0] din,
  input  logic                   pop,
  output logic [FTDI_DATA_W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [FTDI_DATA_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            rd_ptr_nxt;
  logic                   do_pop;
  logic                   full;

  assign empty      = (count == '0);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = pop & ~empty;
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // dout always holds the head entry; a push only lands in dout once it becomes the head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
      if (push && (empty || (count == ONE && do_pop))) begin
        dout <= din;
      end else if (do_pop && count > ONE) begin
        dout <= mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ft232h_rx.sv
// rtl/ft232h_rx.sv - FT232H 245 synchronous FIFO receive engine feeding an AXI-Stream master
module ft232h_rx
  import ftdi_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HEADROOM = 2
) (
  input  logic                   ftdi_clk,
  input  logic                   ftdi_rst,
  input  logic                   rxf_n,
  input  logic [FTDI_DATA_W-1:0] data_in,
  output logic                   rd_n,
  output logic                   oe_n,
  input  logic                   rd_en,
  output logic                   busy,
  output logic [FTDI_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
  localparam logic [CW:0]   HEAD_V  = (CW+1)'(HEADROOM);

  rx_state_t      state;
  logic [CW-1:0]  count;
  logic [CW-1:0]  free;
  logic [CW:0]    room_next;
  logic           fifo_empty;
  logic           capture;
  logic           pop;

  assign free          = DEPTH_V - count;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign capture       = (state == READ) & ~rd_n & ~rxf_n;
  // free space after this edge; HEADROOM >= 1 keeps a slot for the terminating-edge byte
  assign room_next     = {1'b0, free} + {{CW{1'b0}}, pop} - {{CW{1'b0}}, capture};
  assign m_axis_tvalid = ~fifo_empty;

  always_ff @(posedge ftdi_clk) begin
    if (ftdi_rst) begin
      state <= IDLE;
      rd_n  <= 1'b1;
      oe_n  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en && !rxf_n && {1'b0, free} >= HEAD_V) begin
            oe_n  <= 1'b0;
            busy  <= 1'b1;
            state <= TURN;
          end
        end
        TURN: begin
          if (rd_en && !rxf_n) begin
            rd_n  <= 1'b0;
            state <= READ;
          end else begin
            oe_n  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        READ: begin
          if (!(rd_en && !rxf_n && room_next >= HEAD_V)) begin
            rd_n  <= 1'b1;
            oe_n  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          rd_n  <= 1'b1;
          oe_n  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  ft232h_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ftdi_clk),
    .rst   (ftdi_rst),
    .push  (capture),
    .din   (data_in),
    .pop   (pop),
    .dout  (m_axis_tdata),
    .count (count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ft232h_rx.sv
// tb/tb_ft232h_rx.sv - directed bench for ft232h_rx with an FT232H byte-source model and output scoreboard
module tb_ft232h_rx;

  logic       ftdi_clk = 1'b0;
  logic       ftdi_rst;
  logic       rxf_n;
  logic [7:0] data_in;
  logic       rd_n;
  logic       oe_n;
  logic       rd_en;
  logic       busy;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;

  int total = 0;
  int bad   = 0;

  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  bit         cap_pend = 0;
  bit         rst_pend = 0;
  bit         rst_val = 1;
  bit         rd_en_val = 0;
  bit         rdy_val = 0;
  bit         rdy_rand = 0;
  bit         rxf_rand = 0;
  bit         reload = 0;
  logic [7:0] reload_byte = 8'h00;
  logic [7:0] last_pop = 8'h00;
  int         n_cap = 0;
  int         n_pop = 0;

  always #8 ftdi_clk = ~ftdi_clk;

  ft232h_rx #(
    .DEPTH    (8),
    .HEADROOM (2)
  ) dut (
    .ftdi_clk      (ftdi_clk),
    .ftdi_rst      (ftdi_rst),
    .rxf_n         (rxf_n),
    .data_in       (data_in),
    .rd_n          (rd_n),
    .oe_n          (oe_n),
    .rd_en         (rd_en),
    .busy          (busy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One cycle: account for the previous edge, then drive inputs for the next edge.
  task automatic step();
    logic [7:0] b;
    logic [7:0] want;
    @(negedge ftdi_clk);
    if (cap_pend) begin
      b = src.pop_front();
      if (!rst_pend) begin
        exp_q.push_back(b);
        n_cap++;
      end
    end
    if (rst_pend) exp_q.delete();
    if (reload) begin
      src.delete();
      src.push_back(reload_byte);
      reload = 0;
    end
    chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
    ftdi_rst = rst_val;
    rd_en    = rd_en_val;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    rxf_n = (src.size() == 0) || (rxf_rand && ($urandom_range(0, 3) == 0));
    if (rxf_n) data_in = 8'hEE;
    else       data_in = src[0];
    if (m_axis_tvalid && m_axis_tready && !ftdi_rst) begin
      chk("pop_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("data", m_axis_tdata, want);
      end
      last_pop = m_axis_tdata;
      n_pop++;
    end
    cap_pend = !rd_n && !rxf_n;
    rst_pend = ftdi_rst;
  endtask

  initial begin
    int n0;
    int c0;
    int c1;
    int oe_t;
    int rd_t;
    bit got7;

    ftdi_rst = 1'b1;
    rxf_n = 1'b1;
    data_in = 8'h00;
    rd_en = 1'b0;
    m_axis_tready = 1'b0;

    repeat (3) step();
    chk("rst_rd_n", rd_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 8'h00);

    // 1: five-byte burst with a ready sink
    rst_val = 0; rd_en_val = 1; rdy_val = 1;
    step();
    for (int i = 0; i < 5; i++) src.push_back(8'(8'h10 + i));
    n0 = n_pop;
    step();
    chk("t1_oe_idle", oe_n, 1);
    step();
    chk("t1_oe_fall", oe_n, 0);
    chk("t1_rd_turn", rd_n, 1);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_rd_fall", rd_n, 0);
    repeat (5) step();
    chk("t1_rd_hold", rd_n, 0);
    step();
    chk("t1_rd_rise", rd_n, 1);
    chk("t1_oe_rise", oe_n, 1);
    chk("t1_busy_end", busy, 0);
    repeat (3) step();
    chk("t1_pops", n_pop - n0, 5);
    chk("t1_last", last_pop, 8'h14);

    // 2: stalled sink, burst stops on headroom after 7 bytes
    rdy_val = 0;
    c0 = n_cap;
    n0 = n_pop;
    for (int i = 0; i < 20; i++) src.push_back(8'(8'h20 + i));
    got7 = 0;
    for (int i = 0; i < 30 && !got7; i++) begin
      step();
      if (n_cap - c0 == 7) got7 = 1;
    end
    chk("t2_reach7", got7, 1);
    chk("t2_rd_rise", rd_n, 1);
    chk("t2_oe_rise", oe_n, 1);
    repeat (4) step();
    chk("t2_cap7", n_cap - c0, 7);
    chk("t2_tdata", m_axis_tdata, 8'h20);
    chk("t2_tvalid", m_axis_tvalid, 1);
    chk("t2_idle_oe", oe_n, 1);

    // 3: pop two, free reaches 3, second burst of two bytes
    rdy_val = 1;
    repeat (2) step();
    rdy_val = 0;
    oe_t = -1;
    rd_t = -1;
    c1 = n_cap;
    for (int i = 0; i < 15; i++) begin
      step();
      if (oe_t < 0 && !oe_n) oe_t = i;
      if (rd_t < 0 && !rd_n) rd_t = i;
    end
    chk("t3_oe_seen", oe_t >= 0, 1);
    chk("t3_turn", rd_t - oe_t, 1);
    chk("t3_cap2", n_cap - c1, 2);
    rd_en_val = 0;
    rdy_val = 1;
    repeat (10) step();
    chk("t3_pops", n_pop - n0, 9);
    chk("t3_last", last_pop, 8'h28);
    chk("t3_tvalid_end", m_axis_tvalid, 0);

    // 4: grant withdrawn mid-burst
    src.delete();
    for (int i = 0; i < 10; i++) src.push_back(8'(8'h40 + i));
    rd_en_val = 1;
    c0 = n_cap;
    n0 = n_pop;
    repeat (5) step();
    rd_en_val = 0;
    step();
    chk("t4_rd_still", rd_n, 0);
    step();
    chk("t4_rd_n", rd_n, 1);
    chk("t4_oe_n", oe_n, 1);
    chk("t4_busy", busy, 0);
    chk("t4_cap", n_cap - c0, 4);
    repeat (4) step();
    chk("t4_pops", n_pop - n0, 4);
    chk("t4_last", last_pop, 8'h43);

    // 5: reset mid-burst with three bytes buffered
    src.delete();
    for (int i = 0; i < 10; i++) src.push_back(8'(8'h50 + i));
    rd_en_val = 1;
    rdy_val = 0;
    repeat (5) step();
    rst_val = 1;
    step();
    chk("t5_buffered", m_axis_tvalid, 1);
    rst_val = 0;
    reload = 1;
    reload_byte = 8'hA5;
    step();
    chk("t5_rd_n", rd_n, 1);
    chk("t5_oe_n", oe_n, 1);
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_busy", busy, 0);
    rdy_val = 1;
    n0 = n_pop;
    repeat (10) step();
    chk("t5_pops", n_pop - n0, 1);
    chk("t5_byte", last_pop, 8'hA5);

    // 6: irregular rxf_n and random tready
    for (int i = 0; i < 40; i++) src.push_back(8'(i * 37 + 5));
    rxf_rand = 1;
    rdy_rand = 1;
    n0 = n_pop;
    for (int i = 0; i < 2000 && (n_pop - n0) < 40; i++) step();
    chk("t6_pops", n_pop - n0, 40);
    rxf_rand = 0;
    rdy_rand = 0;
    rdy_val = 1;
    repeat (3) step();
    chk("t6_tvalid_end", m_axis_tvalid, 0);
    chk("t6_rd_n_end", rd_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
